wb_write_queue: RTL and testbench

- Write-back initiator for the 32x32 register file's single write port.
- Accepts write requests from two producers: the ALU and the load unit. Each producer uses a valid/ready handshake.
- Buffers requests in an in-order queue and drains at most one per cycle onto the register file's wsel/D/en inputs.
- Provides two bypass lookup ports so the register-read stage sees pending (not yet written) values.

---
 rtl/wb_write_queue_if.sv | 39 +++
 rtl/wb_write_queue.sv | 109 ++++++++++
 tb/tb_wb_write_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Producer, drain and bypass signals of the write-back queue.
// The queue takes the slave side; the environment driving it takes the master side.
interface wb_write_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_valid;
  logic [4:0]    mem_sel;
  logic [31:0]   mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [4:0]    alu_sel;
  logic [31:0]   alu_data;
  logic          alu_ready;
  logic          hold;
  logic [4:0]    wsel;
  logic [31:0]   wdata;
  logic          wen;
  logic [4:0]    rsel1;
  logic          hit1;
  logic [31:0]   fwd1;
  logic [4:0]    rsel2;
  logic          hit2;
  logic [31:0]   fwd2;
  logic [CW-1:0] count;

  modport slave (
    input  mem_valid, mem_sel, mem_data, alu_valid, alu_sel, alu_data,
    input  hold, rsel1, rsel2,
    output mem_ready, alu_ready, wsel, wdata, wen,
    output hit1, fwd1, hit2, fwd2, count
  );

  modport master (
    output mem_valid, mem_sel, mem_data, alu_valid, alu_sel, alu_data,
    output hold, rsel1, rsel2,
    input  mem_ready, alu_ready, wsel, wdata, wen,
    input  hit1, fwd1, hit2, fwd2, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port from the
// load unit and the ALU, with two bypass lookup ports over pending entries.
module wb_write_queue #(
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  wb_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [4:0]       r_sel  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [CW-1:0]    w_free;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_mem_enq;
  logic             w_alu_enq;
  logic             w_pop;
  logic [AW-1:0]    w_alu_slot;
  logic [CW-1:0]    w_n_enq;
  logic             w_hit1;
  logic             w_hit2;
  logic [31:0]      w_fwd1;
  logic [31:0]      w_fwd2;

  // Space is judged on the registered count only, so a pop never frees room
  // for an accept in the same cycle.
  assign w_free         = CW'(DEPTH) - r_count;
  assign bus.mem_ready  = (w_free != '0);
  assign bus.alu_ready  = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !bus.mem_valid);

  assign w_mem_acc  = bus.mem_valid && bus.mem_ready;
  assign w_alu_acc  = bus.alu_valid && bus.alu_ready;
  assign w_mem_enq  = w_mem_acc && (bus.mem_sel != ZR);
  assign w_alu_enq  = w_alu_acc && (bus.alu_sel != ZR);
  assign w_alu_slot = r_tail + AW'(w_mem_enq);
  assign w_n_enq    = CW'(w_mem_enq) + CW'(w_alu_enq);

  // Gating with rst keeps a queued write from landing on the reset edge.
  assign w_pop     = (r_count != '0) && !bus.hold && rst;
  assign bus.wen   = w_pop;
  assign bus.wsel  = (r_count != '0) ? r_sel[r_head]  : 5'd0;
  assign bus.wdata = (r_count != '0) ? r_data[r_head] : 32'd0;
  assign bus.count = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_sel[i]  <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      if (w_mem_enq) begin
        r_sel[r_tail]  <= bus.mem_sel;
        r_data[r_tail] <= bus.mem_data;
        r_vld[r_tail]  <= 1'b1;
      end
      if (w_alu_enq) begin
        r_sel[w_alu_slot]  <= bus.alu_sel;
        r_data[w_alu_slot] <= bus.alu_data;
        r_vld[w_alu_slot]  <= 1'b1;
      end
      r_tail  <= r_tail + AW'(w_n_enq);
      r_count <= r_count + w_n_enq - CW'(w_pop);
    end
  end

  // Walk from head toward tail so the last match seen is the youngest entry.
  always_comb begin
    w_hit1 = 1'b0;
    w_fwd1 = 32'd0;
    w_hit2 = 1'b0;
    w_fwd2 = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[r_head + AW'(k)] && (bus.rsel1 != ZR) &&
          (r_sel[r_head + AW'(k)] == bus.rsel1)) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_data[r_head + AW'(k)];
      end
      if (r_vld[r_head + AW'(k)] && (bus.rsel2 != ZR) &&
          (r_sel[r_head + AW'(k)] == bus.rsel2)) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_data[r_head + AW'(k)];
      end
    end
  end

  assign bus.hit1 = w_hit1;
  assign bus.fwd1 = w_fwd1;
  assign bus.hit2 = w_hit2;
  assign bus.fwd2 = w_fwd2;
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table for the key sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_write_queue_if #(.DEPTH(4)) bus ();
  wb_write_queue #(.DEPTH(4), .ZERO_REG(31)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic rst; logic mv; logic [4:0] ms; logic [31:0] md;
    logic av; logic [4:0] asel; logic [31:0] ad; logic hold;
    logic [4:0] r1; logic [4:0] r2;
    int cnt; logic wen; logic [4:0] wsel; logic [31:0] wdata;
    logic mr; logic ar; logic h1; logic [31:0] f1; logic h2; logic [31:0] f2;
  } vec_t;
  vec_t tbl[$];

  typedef struct { logic [4:0] sel; logic [31:0] data; } ent_t;
  ent_t q[$];

  logic m_mr, m_ar, m_wen, m_h1, m_h2;
  logic [4:0] m_wsel;
  logic [31:0] m_wdata, m_f1, m_f2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    bus.mem_valid = v.mv; bus.mem_sel = v.ms; bus.mem_data = v.md;
    bus.alu_valid = v.av; bus.alu_sel = v.asel; bus.alu_data = v.ad;
    bus.hold = v.hold; bus.rsel1 = v.r1; bus.rsel2 = v.r2;
  endtask

  task automatic lookup(input logic [4:0] r, output logic h, output logic [31:0] f);
    h = 1'b0; f = 32'd0;
    if (r != 5'd31) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].sel == r) begin
          h = 1'b1; f = q[i].data; break;
        end
      end
    end
  endtask

  task automatic mdl_eval();
    int fr;
    fr      = 4 - q.size();
    m_mr    = (fr >= 1);
    m_ar    = (fr >= 2) || (fr == 1 && !bus.mem_valid);
    m_wen   = (q.size() != 0) && !bus.hold;
    m_wsel  = (q.size() != 0) ? q[0].sel  : 5'd0;
    m_wdata = (q.size() != 0) ? q[0].data : 32'd0;
    lookup(bus.rsel1, m_h1, m_f1);
    lookup(bus.rsel2, m_h2, m_f2);
  endtask

  task automatic mdl_update();
    ent_t e;
    if (!rst) begin
      q.delete();
    end else begin
      if (m_wen) void'(q.pop_front());
      if (bus.mem_valid && m_mr && bus.mem_sel != 5'd31) begin
        e.sel = bus.mem_sel; e.data = bus.mem_data; q.push_back(e);
      end
      if (bus.alu_valid && m_ar && bus.alu_sel != 5'd31) begin
        e.sel = bus.alu_sel; e.data = bus.alu_data; q.push_back(e);
      end
    end
  endtask

  initial begin
    // inputs | expected: cnt wen wsel wdata mem_rdy alu_rdy hit1 fwd1 hit2 fwd2
    tbl.push_back('{1,0,0,0,0,0,0,0,0,0,          0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,1,5,'hAAAA0005,1,6,'h6,0,5,6, 0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,5,6,          2,1,5,'hAAAA0005,1,1,1,'hAAAA0005,1,'h6});
    tbl.push_back('{1,0,0,0,0,0,0,0,5,6,          1,1,6,'h6,1,1,0,0,1,'h6});
    tbl.push_back('{1,0,0,0,0,0,0,0,5,6,          0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,3,1,1,3,0,          0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,3,2,1,3,0,          1,0,3,1,1,1,1,1,0,0});
    tbl.push_back('{1,0,0,0,1,3,3,1,3,0,          2,0,3,1,1,1,1,2,0,0});
    tbl.push_back('{1,0,0,0,1,3,4,1,3,0,          3,0,3,1,1,1,1,3,0,0});
    tbl.push_back('{1,0,0,0,1,3,5,1,3,0,          4,0,3,1,0,0,1,4,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,3,0,          4,1,3,1,0,0,1,4,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,3,0,          3,1,3,2,1,1,1,4,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,3,0,          2,1,3,3,1,1,1,4,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,3,0,          1,1,3,4,1,1,1,4,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,3,0,          0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,7,'h70,1,9,8,       0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,7,'h71,1,9,8,       1,0,7,'h70,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,7,'h72,1,9,8,       2,0,7,'h70,1,1,0,0,0,0});
    tbl.push_back('{1,1,8,'h80,1,9,'h90,1,9,8,    3,0,7,'h70,1,0,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,9,'h90,0,9,8,       4,1,7,'h70,0,0,0,0,1,'h80});
    tbl.push_back('{1,0,0,0,1,9,'h90,0,9,8,       3,1,7,'h71,1,1,0,0,1,'h80});
    tbl.push_back('{1,0,0,0,0,0,0,0,9,8,          3,1,7,'h72,1,1,1,'h90,1,'h80});
    tbl.push_back('{1,0,0,0,0,0,0,0,9,8,          2,1,8,'h80,1,1,1,'h90,1,'h80});
    tbl.push_back('{1,0,0,0,0,0,0,0,9,8,          1,1,9,'h90,1,1,1,'h90,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,9,8,          0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,31,'hDEAD,0,31,31,  0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,31,31,        0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,1,31,'h1,1,2,'h22,0,2,31,   0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,2,31,         1,1,2,'h22,1,1,1,'h22,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,2,31,         0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,10,'hA1,1,10,0,     0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,1,10,'hA2,1,10,0,     1,0,10,'hA1,1,1,1,'hA1,0,0});
    tbl.push_back('{1,0,0,0,1,10,'hA3,1,10,0,     2,0,10,'hA1,1,1,1,'hA2,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1,10,0,         3,0,10,'hA1,1,1,1,'hA3,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,10,0,         0,0,0,0,1,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0,10,0,         0,0,0,0,1,1,0,0,0,0});

    drive(tbl[0]);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.wen", i), 32'(bus.wen), 32'(tbl[i].wen));
      chk($sformatf("v%0d.wsel", i), 32'(bus.wsel), 32'(tbl[i].wsel));
      chk($sformatf("v%0d.wdata", i), bus.wdata, tbl[i].wdata);
      chk($sformatf("v%0d.mem_ready", i), 32'(bus.mem_ready), 32'(tbl[i].mr));
      chk($sformatf("v%0d.alu_ready", i), 32'(bus.alu_ready), 32'(tbl[i].ar));
      chk($sformatf("v%0d.hit1", i), 32'(bus.hit1), 32'(tbl[i].h1));
      chk($sformatf("v%0d.fwd1", i), bus.fwd1, tbl[i].f1);
      chk($sformatf("v%0d.hit2", i), 32'(bus.hit2), 32'(tbl[i].h2));
      chk($sformatf("v%0d.fwd2", i), bus.fwd2, tbl[i].f2);
      mdl_eval();
      mdl_update();
      @(posedge clk);
      @(negedge clk);
    end

    for (int c = 0; c < 400; c++) begin
      rst = 1'b1;
      bus.mem_valid = ($urandom_range(0, 9) < 6);
      bus.mem_sel   = 5'($urandom_range(24, 31));
      bus.mem_data  = $urandom;
      bus.alu_valid = ($urandom_range(0, 9) < 6);
      bus.alu_sel   = 5'($urandom_range(24, 31));
      bus.alu_data  = $urandom;
      bus.hold      = ($urandom_range(0, 9) < 3);
      bus.rsel1     = 5'($urandom_range(24, 31));
      bus.rsel2     = 5'($urandom_range(24, 31));
      #1;
      mdl_eval();
      chk("rnd.count", 32'(bus.count), 32'(q.size()));
      chk("rnd.wen", 32'(bus.wen), 32'(m_wen));
      chk("rnd.wsel", 32'(bus.wsel), 32'(m_wsel));
      chk("rnd.wdata", bus.wdata, m_wdata);
      chk("rnd.mem_ready", 32'(bus.mem_ready), 32'(m_mr));
      chk("rnd.alu_ready", 32'(bus.alu_ready), 32'(m_ar));
      chk("rnd.hit1", 32'(bus.hit1), 32'(m_h1));
      chk("rnd.fwd1", bus.fwd1, m_f1);
      chk("rnd.hit2", 32'(bus.hit2), 32'(m_h2));
      chk("rnd.fwd2", bus.fwd2, m_f2);
      mdl_update();
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
